// File: rtl/ni_pkg.sv
// Shared encodings and sizing helpers for the processor<->NoC network interface.
package ni_pkg;

    localparam logic [1:0] T_IDLE = 2'd0;
    localparam logic [1:0] T_HEAD = 2'd1;
    localparam logic [1:0] T_BODY = 2'd2;
    localparam logic [1:0] T_TAIL = 2'd3;

    localparam logic [1:0] R_HEAD = 2'd0;
    localparam logic [1:0] R_BODY = 2'd1;
    localparam logic [1:0] R_TAIL = 2'd2;
    localparam logic [1:0] R_DONE = 2'd3;

    localparam logic [5:0] HDR_TAG_DEF = 6'b101111;
    localparam logic       TAIL_BIT_DEF = 1'b1;

    function automatic int nflit(input int dw, input int fw);
        return dw / fw;
    endfunction

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ni_sync_fifo.sv
// Single-clock FIFO with combinational read of the oldest entry.
module ni_sync_fifo #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q;
    logic [AW-1:0]    rptr_q;
    logic [AW:0]      cnt_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rptr_q];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) begin
                wptr_q <= wptr_q + AW'(1);
            end
            if (do_pop) begin
                rptr_q <= rptr_q + AW'(1);
            end
            if (do_push && !do_pop) begin
                cnt_q <= cnt_q + (AW+1)'(1);
            end else if (do_pop && !do_push) begin
                cnt_q <= cnt_q - (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/ni_packet_engine.sv
// Full-duplex network interface: TX serialises buffered words into
// HEAD/BODY/TAIL flits, RX reassembles and checks incoming packets.
module ni_packet_engine import ni_pkg::*; #(
    parameter int                        DATA_W   = 32,
    parameter int                        FLIT_W   = 8,
    parameter int                        ADDR_W   = 2,
    parameter logic [FLIT_W-ADDR_W-1:0]  HDR_TAG  = (FLIT_W-ADDR_W)'(HDR_TAG_DEF),
    parameter logic [FLIT_W-1:0]         TAIL     = {FLIT_W{TAIL_BIT_DEF}},
    parameter int                        TX_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] dest_add,
    input  logic [DATA_W-1:0] proc_data_in,
    input  logic              proc_valid,
    output logic              proc_ready,
    output logic [DATA_W-1:0] proc_data_out,
    output logic              data_valid,
    input  logic              proc_ready_in,
    input  logic [FLIT_W-1:0] flit_in,
    input  logic              flit_in_valid,
    output logic              ni_ready,
    output logic [FLIT_W-1:0] flit_out,
    output logic              flit_valid,
    input  logic              noc_ready,
    output logic              rx_err
);

    localparam int NFLIT = nflit(DATA_W, FLIT_W);
    localparam int CW    = cnt_w(NFLIT);
    localparam int EW    = ADDR_W + DATA_W;

    logic [EW-1:0]     fifo_rdata;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_pop;
    logic [FLIT_W-1:0] head_flit;
    logic              tx_xfer;

    logic [1:0]        tx_st_q, tx_st_d;
    logic [DATA_W-1:0] tx_word_q, tx_word_d;
    logic [CW-1:0]     tx_cnt_q, tx_cnt_d;
    logic [FLIT_W-1:0] flit_q, flit_d;
    logic              fv_q, fv_d;

    ni_sync_fifo #(
        .WIDTH (EW),
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (proc_valid),
        .wdata_i ({dest_add, proc_data_in}),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign proc_ready = !fifo_full;
    assign head_flit  = {HDR_TAG, fifo_rdata[EW-1 -: ADDR_W]};
    assign tx_xfer    = fv_q && noc_ready;
    assign flit_out   = flit_q;
    assign flit_valid = fv_q;

    always_comb begin
        tx_st_d   = tx_st_q;
        tx_word_d = tx_word_q;
        tx_cnt_d  = tx_cnt_q;
        flit_d    = flit_q;
        fv_d      = fv_q;
        fifo_pop  = 1'b0;
        unique case (tx_st_q)
            T_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    flit_d    = head_flit;
                    fv_d      = 1'b1;
                    tx_word_d = fifo_rdata[DATA_W-1:0];
                    tx_st_d   = T_HEAD;
                end
            end
            T_HEAD: begin
                if (tx_xfer) begin
                    flit_d    = tx_word_q[DATA_W-1 -: FLIT_W];
                    tx_word_d = tx_word_q << FLIT_W;
                    tx_cnt_d  = '0;
                    tx_st_d   = T_BODY;
                end
            end
            T_BODY: begin
                if (tx_xfer) begin
                    if (tx_cnt_q == CW'(NFLIT - 1)) begin
                        flit_d   = TAIL;
                        tx_cnt_d = '0;
                        tx_st_d  = T_TAIL;
                    end else begin
                        flit_d    = tx_word_q[DATA_W-1 -: FLIT_W];
                        tx_word_d = tx_word_q << FLIT_W;
                        tx_cnt_d  = tx_cnt_q + CW'(1);
                    end
                end
            end
            T_TAIL: begin
                // back-to-back packets: next head replaces the tail directly
                if (tx_xfer) begin
                    if (!fifo_empty) begin
                        fifo_pop  = 1'b1;
                        flit_d    = head_flit;
                        tx_word_d = fifo_rdata[DATA_W-1:0];
                        tx_st_d   = T_HEAD;
                    end else begin
                        fv_d    = 1'b0;
                        tx_st_d = T_IDLE;
                    end
                end
            end
            default: tx_st_d = T_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_st_q   <= T_IDLE;
            tx_word_q <= '0;
            tx_cnt_q  <= '0;
            flit_q    <= '0;
            fv_q      <= 1'b0;
        end else begin
            tx_st_q   <= tx_st_d;
            tx_word_q <= tx_word_d;
            tx_cnt_q  <= tx_cnt_d;
            flit_q    <= flit_d;
            fv_q      <= fv_d;
        end
    end

    logic [1:0]        rx_st_q, rx_st_d;
    logic [DATA_W-1:0] rx_word_q, rx_word_d;
    logic [CW-1:0]     rx_cnt_q, rx_cnt_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              dv_q, dv_d;
    logic              err_q, err_d;
    logic              rx_xfer;

    assign ni_ready      = (rx_st_q != R_DONE);
    assign rx_xfer       = flit_in_valid && ni_ready;
    assign proc_data_out = dout_q;
    assign data_valid    = dv_q;
    assign rx_err        = err_q;

    always_comb begin
        rx_st_d   = rx_st_q;
        rx_word_d = rx_word_q;
        rx_cnt_d  = rx_cnt_q;
        dout_d    = dout_q;
        dv_d      = dv_q;
        err_d     = 1'b0;
        unique case (rx_st_q)
            R_HEAD: begin
                if (rx_xfer) begin
                    if (flit_in[FLIT_W-1:ADDR_W] != HDR_TAG) begin
                        err_d = 1'b1;
                    end else begin
                        rx_cnt_d = '0;
                        rx_st_d  = R_BODY;
                    end
                end
            end
            R_BODY: begin
                if (rx_xfer) begin
                    rx_word_d = (rx_word_q << FLIT_W) | DATA_W'(flit_in);
                    if (rx_cnt_q == CW'(NFLIT - 1)) begin
                        rx_st_d = R_TAIL;
                    end else begin
                        rx_cnt_d = rx_cnt_q + CW'(1);
                    end
                end
            end
            R_TAIL: begin
                if (rx_xfer) begin
                    if (flit_in == TAIL) begin
                        dout_d  = rx_word_q;
                        dv_d    = 1'b1;
                        rx_st_d = R_DONE;
                    end else begin
                        err_d   = 1'b1;
                        rx_st_d = R_HEAD;
                    end
                end
            end
            R_DONE: begin
                if (proc_ready_in) begin
                    dv_d    = 1'b0;
                    rx_st_d = R_HEAD;
                end
            end
            default: rx_st_d = R_HEAD;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_st_q   <= R_HEAD;
            rx_word_q <= '0;
            rx_cnt_q  <= '0;
            dout_q    <= '0;
            dv_q      <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            rx_st_q   <= rx_st_d;
            rx_word_q <= rx_word_d;
            rx_cnt_q  <= rx_cnt_d;
            dout_q    <= dout_d;
            dv_q      <= dv_d;
            err_q     <= err_d;
        end
    end

endmodule
